// File: rtl/collision_matrix_pkg.sv
// Shared helpers for the collision matrix: pair counting, pair-index to
// object-index mapping and the width of a pair identifier.
package collision_pkg;

  // Number of unordered object pairs for n objects.
  function automatic int num_pairs(input int n);
    return (n * (n - 1)) / 2;
  endfunction

  // Width of a pair identifier; never less than one bit.
  function automatic int pair_w(input int n);
    int np;
    np = num_pairs(n);
    return (np > 1) ? $clog2(np) : 1;
  endfunction

  // First object i of pair p, pairs enumerated (i,j), i<j, lexicographically.
  function automatic int pair_i(input int n, input int p);
    int base;
    int res;
    base = 0;
    res  = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < n - 1) begin
        if ((p >= base) && (p < base + (n - 1 - i))) res = i;
        base = base + (n - 1 - i);
      end
    end
    return res;
  endfunction

  // Second object j of pair p.
  function automatic int pair_j(input int n, input int p);
    int base;
    int res;
    base = 0;
    res  = 1;
    for (int i = 0; i < 8; i++) begin
      if (i < n - 1) begin
        if ((p >= base) && (p < base + (n - 1 - i))) res = i + 1 + (p - base);
        base = base + (n - 1 - i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/collision_matrix_if.sv
// Hit-event stream: the matrix presents one pair index per event and the
// consumer takes it with a valid/ready handshake.
interface collision_matrix_if
  import collision_pkg::*;
#(
  parameter int PAIR_W = pair_w(4)
) ();
  logic              evt_valid;
  logic [PAIR_W-1:0] evt_pair;
  logic              evt_ready;

  modport master (output evt_valid, output evt_pair, input evt_ready);
  modport slave  (input evt_valid, input evt_pair, output evt_ready);
endinterface

// File: rtl/collision_matrix_hit_event_fifo.sv
// Small synchronous FIFO holding pair indices of hit events.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module hit_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  // Head is forced to zero while empty so stale storage never shows.
  assign pop_data  = empty ? '0 : mem_q[rd_q[AW-1:0]];

  // Pointer update; pointers carry one wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push_s) wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents are meaningless until the pointers cover them.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_q[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/collision_matrix.sv
// Pairwise collision detector for per-pixel drawing requests: flags each
// object pair once per frame, queues the hit events and counts hits per frame.
module collision_matrix
  import collision_pkg::*;
#(
  parameter int                              NUM_OBJ   = 4,
  parameter logic [num_pairs(NUM_OBJ)-1:0]   PAIR_MASK = '1,
  parameter int                              EDGE_MODE = 0,
  parameter int                              EVT_DEPTH = 4,
  parameter int                              CNT_W     = 8
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           startOfFrame,
  input  logic [NUM_OBJ-1:0]             draw_req,
  collision_matrix_if.master             evt,
  output logic                           collision,
  output logic [num_pairs(NUM_OBJ)-1:0]  hit_pulse,
  output logic                           evt_overflow,
  output logic [CNT_W-1:0]               frame_hits
);
  localparam int NP = num_pairs(NUM_OBJ);
  localparam int PW = pair_w(NUM_OBJ);
  localparam int SW = CNT_W + 6;
  localparam logic [SW-1:0] CNT_MAX = {6'b000000, {CNT_W{1'b1}}};
  localparam logic [NP-1:0] ONE_P   = NP'(1'b1);

  logic [NP-1:0]    overlap_s, qual_s, prev_eff_s, flag_eff_s, pend_all_s;
  logic [NP-1:0]    flag_q, flag_d, seen_cur_q, seen_cur_d, seen_prev_q, seen_prev_d;
  logic [NP-1:0]    pending_q, pending_d, hit_pulse_q;
  logic [PW-1:0]    push_idx_s;
  logic             push_req_s, fifo_full_s, fifo_empty_s, drop_s, overflow_q;
  logic [SW-1:0]    pc_s, sum_s;
  logic [CNT_W-1:0] sat_s, cnt_q, cnt_d, frame_hits_q, frame_hits_d;

  for (genvar p = 0; p < NP; p++) begin : g_pair
    localparam int PI = pair_i(NUM_OBJ, p);
    localparam int PJ = pair_j(NUM_OBJ, p);
    assign overlap_s[p] = draw_req[PI] & draw_req[PJ] & PAIR_MASK[p];
  end

  assign collision = |overlap_s;

  // Qualify overlaps; at frame start the overlap already belongs to the new frame.
  always_comb begin
    prev_eff_s = seen_prev_q;
    flag_eff_s = flag_q;
    if (startOfFrame) begin
      prev_eff_s  = seen_cur_q;
      flag_eff_s  = '0;
      seen_cur_d  = overlap_s;
      seen_prev_d = seen_cur_q;
    end else begin
      seen_cur_d  = seen_cur_q | overlap_s;
      seen_prev_d = seen_prev_q;
    end
    if (EDGE_MODE != 0) begin
      qual_s = overlap_s & ~flag_eff_s & ~prev_eff_s;
    end else begin
      qual_s = overlap_s & ~flag_eff_s;
    end
    flag_d = flag_eff_s | qual_s;
  end

  // Pick the lowest pending pair for the FIFO and retire it whether or not it fits.
  always_comb begin
    pend_all_s = pending_q | hit_pulse_q;
    push_req_s = |pend_all_s;
    push_idx_s = '0;
    for (int p = NP - 1; p >= 0; p--) begin
      push_idx_s = pend_all_s[p] ? PW'(p) : push_idx_s;
    end
    pending_d = pend_all_s & ~(ONE_P << push_idx_s);
    drop_s    = push_req_s & fifo_full_s & ~evt.evt_ready;
  end

  // Saturating per-frame hit count; the closing frame includes this cycle's pulses.
  always_comb begin
    pc_s = '0;
    for (int p = 0; p < NP; p++) begin
      pc_s = pc_s + SW'(hit_pulse_q[p]);
    end
    sum_s = SW'(cnt_q) + pc_s;
    sat_s = (sum_s > CNT_MAX) ? {CNT_W{1'b1}} : sum_s[CNT_W-1:0];
    if (startOfFrame) begin
      cnt_d        = '0;
      frame_hits_d = sat_s;
    end else begin
      cnt_d        = sat_s;
      frame_hits_d = frame_hits_q;
    end
  end

  // All matrix state; reset drops pending work and history.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      flag_q       <= '0;
      seen_cur_q   <= '0;
      seen_prev_q  <= '0;
      pending_q    <= '0;
      hit_pulse_q  <= '0;
      overflow_q   <= 1'b0;
      cnt_q        <= '0;
      frame_hits_q <= '0;
    end else begin
      flag_q       <= flag_d;
      seen_cur_q   <= seen_cur_d;
      seen_prev_q  <= seen_prev_d;
      pending_q    <= pending_d;
      hit_pulse_q  <= qual_s;
      overflow_q   <= overflow_q | drop_s;
      cnt_q        <= cnt_d;
      frame_hits_q <= frame_hits_d;
    end
  end

  hit_event_fifo #(
    .DEPTH (EVT_DEPTH),
    .WIDTH (PW)
  ) u_fifo (
    .clk       (clk),
    .resetN    (resetN),
    .push      (push_req_s),
    .push_data (push_idx_s),
    .pop       (evt.evt_ready),
    .pop_data  (evt.evt_pair),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign evt.evt_valid = ~fifo_empty_s;
  assign hit_pulse     = hit_pulse_q;
  assign evt_overflow  = overflow_q;
  assign frame_hits    = frame_hits_q;
endmodule

// File: tb/tb_collision_matrix.sv
// Bench for collision_matrix: default instance with an event scoreboard,
// a pair-masked instance and an edge-mode instance, sharing clock and frame start.
module tb_collision_matrix;
  logic       clk;
  logic       resetN;
  logic       sof;
  logic [3:0] draw0, draw1, draw2;
  logic       col0, col1, col2;
  logic [5:0] hp0, hp1, hp2;
  logic       ov0, ov1, ov2;
  logic [7:0] fh0, fh1, fh2;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int mon_exp;
  int hp_total, hp_first, cnt;
  logic [5:0] hp_or;

  collision_matrix_if #(.PAIR_W(3)) ev0 ();
  collision_matrix_if #(.PAIR_W(3)) ev1 ();
  collision_matrix_if #(.PAIR_W(3)) ev2 ();

  collision_matrix u0 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .draw_req(draw0), .evt(ev0),
    .collision(col0), .hit_pulse(hp0), .evt_overflow(ov0), .frame_hits(fh0));

  collision_matrix #(.PAIR_MASK(6'b111110)) u1 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .draw_req(draw1), .evt(ev1),
    .collision(col1), .hit_pulse(hp1), .evt_overflow(ov1), .frame_hits(fh1));

  collision_matrix #(.EDGE_MODE(1)) u2 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .draw_req(draw2), .evt(ev2),
    .collision(col2), .hit_pulse(hp2), .evt_overflow(ov2), .frame_hits(fh2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame of the edge-mode instance; counts hit_pulse[0] cycles in it.
  task automatic edge_frame(input bit ov, output int c);
    sof = 1'b1;
    tick();
    sof = 1'b0;
    c = 0;
    for (int k = 0; k < 2; k++) begin
      draw2 = ov ? 4'b0011 : 4'b0000;
      tick();
      c += int'(hp2[0]);
    end
    draw2 = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      c += int'(hp2[0]);
    end
  endtask

  // Scoreboard: every accepted event must match the oldest expected pair.
  always @(negedge clk) begin
    if (resetN && ev0.evt_valid && ev0.evt_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("evt_extra", exp_q.size(), 1);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("evt_pair", 32'(ev0.evt_pair), mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0; sof = 1'b0;
    draw0 = 4'b0000; draw1 = 4'b0000; draw2 = 4'b0000;
    ev0.evt_ready = 1'b0; ev1.evt_ready = 1'b1; ev2.evt_ready = 1'b1;
    repeat (2) tick();
    check_eq("rst_valid", ev0.evt_valid, 0);
    check_eq("rst_pulse", hp0, 0);
    check_eq("rst_hits", fh0, 0);
    check_eq("rst_ovf", ov0, 0);
    resetN = 1'b1;
    tick();

    // Two objects overlapping for ten cycles mid-frame
    sof = 1'b1; tick(); sof = 1'b0;
    ev0.evt_ready = 1'b1;
    exp_q.push_back(0);
    hp_total = 0; hp_first = -1; hp_or = '0;
    for (int i = 0; i < 10; i++) begin
      draw0 = 4'b0011;
      #1;
      check_eq("A_collision", col0, 1);
      tick();
      if ((hp0 != 6'b000000) && (hp_first < 0)) hp_first = i;
      hp_total += $countones(hp0);
      hp_or = hp_or | hp0;
    end
    draw0 = 4'b0000;
    #1;
    check_eq("A_col_off", col0, 0);
    tick();
    hp_total += $countones(hp0);
    check_eq("A_pulse_count", hp_total, 1);
    check_eq("A_pulse_cycle", hp_first, 0);
    check_eq("A_pulse_bits", hp_or, 6'b000001);
    repeat (3) tick();
    sof = 1'b1; tick(); sof = 1'b0;
    check_eq("A_frame_hits", fh0, 1);
    check_eq("A_fifo_empty", ev0.evt_valid, 0);

    // Frame start coincident with first overlap of pair 5
    draw0 = 4'b0011; exp_q.push_back(0);
    tick();
    draw0 = 4'b0000;
    tick();
    sof = 1'b1; draw0 = 4'b1100; exp_q.push_back(5);
    tick();
    check_eq("B_old_count", fh0, 1);
    check_eq("B_pulse5", hp0, 6'b100000);
    draw0 = 4'b0000;
    tick();
    sof = 1'b0;
    check_eq("B_new_count", fh0, 1);
    repeat (4) tick();

    // All objects overlap with a stalled consumer: four queued, two dropped
    ev0.evt_ready = 1'b0;
    draw0 = 4'b1111;
    for (int p = 0; p < 4; p++) exp_q.push_back(p);
    tick();
    draw0 = 4'b0000;
    check_eq("C_pulse_all", hp0, 6'b111111);
    repeat (8) tick();
    check_eq("C_overflow", ov0, 1);
    check_eq("C_valid", ev0.evt_valid, 1);
    check_eq("C_head", ev0.evt_pair, 0);
    repeat (3) tick();
    check_eq("C_head_stable", ev0.evt_pair, 0);
    ev0.evt_ready = 1'b1;
    repeat (6) tick();
    check_eq("C_drained", ev0.evt_valid, 0);
    check_eq("C_sb_empty", exp_q.size(), 0);
    sof = 1'b1; tick(); sof = 1'b0;
    check_eq("C_frame_hits", fh0, 6);

    // Masked pair 0 never reports; enabled pair 1 still does
    draw1 = 4'b0011;
    #1;
    check_eq("D_masked_col", col1, 0);
    tick();
    check_eq("D_masked_pulse", hp1, 0);
    draw1 = 4'b0101;
    #1;
    check_eq("D_enabled_col", col1, 1);
    tick();
    check_eq("D_enabled_pulse", hp1, 6'b000010);
    draw1 = 4'b0000;
    repeat (3) tick();
    check_eq("D_evt_drained", ev1.evt_valid, 0);

    // Edge mode: contact in frames 1, 2 and 4
    edge_frame(1'b1, cnt); check_eq("E_frame1", cnt, 1);
    edge_frame(1'b1, cnt); check_eq("E_frame2", cnt, 0);
    edge_frame(1'b0, cnt); check_eq("E_frame3", cnt, 0);
    edge_frame(1'b1, cnt); check_eq("E_frame4", cnt, 1);

    // Reset with three queued events
    ev0.evt_ready = 1'b0;
    draw0 = 4'b0111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    tick();
    draw0 = 4'b0000;
    repeat (4) tick();
    sof = 1'b1; tick(); sof = 1'b0;
    check_eq("F_frame_hits", fh0, 3);
    check_eq("F_queued", ev0.evt_valid, 1);
    #2;
    resetN = 1'b0;
    #1;
    check_eq("F_rst_valid", ev0.evt_valid, 0);
    check_eq("F_rst_hits", fh0, 0);
    check_eq("F_rst_ovf", ov0, 0);
    check_eq("F_rst_pair", ev0.evt_pair, 0);
    exp_q.delete();
    tick();
    resetN = 1'b1;
    ev0.evt_ready = 1'b1;
    repeat (4) tick();
    check_eq("F_post_valid", ev0.evt_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
